serial_shift_arbiter: RTL and testbench

Arbitrates two parallel-word requesters onto one serial shift-register datapath (single-bit `sIn`/`sOut`, fixed DEPTH-cycle latency). A granted word is serialized MSB-first into `sIn`. The returning `sOut` stream is captured DEPTH cycles later and reassembled into a response word for the winning requester. The block sits between the requester logic and the shift register and is that register's only driver.

---
 rtl/serial_shift_arbiter.sv | 210 +++++++++++++++++++++
 tb/tb_serial_shift_arbiter.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/serial_shift_arbiter.sv
// serial_shift_arbiter
// Round-robin arbiter between two parallel-word requesters that share one
// serial shift-register datapath. The granted word is sent MSB-first on sIn.
// The stream returning on sOut is captured DEPTH cycles later, reassembled,
// and returned with the requester id and a mismatch flag.
module serial_shift_arbiter #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic             req1,
  input  logic [WIDTH-1:0] data0,
  input  logic [WIDTH-1:0] data1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             sIn,
  input  logic             sOut,
  output logic [WIDTH-1:0] rdata,
  output logic             rid,
  output logic             rvalid,
  output logic             rerr,
  output logic             busy
);

  // The counter must reach WIDTH+DEPTH-1, the last RUN cycle.
  localparam int CW = $clog2(WIDTH + DEPTH + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH + DEPTH - 1);
  localparam logic [CW-1:0] CNT_CAP  = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic             r_ptr;     // last-served requester
  logic [WIDTH-1:0] r_word;    // word as granted, kept for the error check
  logic [WIDTH-1:0] r_tx;      // serializer; bits still to send sit at the top
  logic             r_id;
  logic [WIDTH-1:0] r_cap;
  logic             r_gnt0;
  logic             r_gnt1;
  logic             r_sin;
  logic [WIDTH-1:0] r_rdata;
  logic             r_rid;
  logic             r_rvalid;
  logic             r_rerr;
  logic             r_busy;

  state_t           w_state;
  logic [CW-1:0]    w_cnt;
  logic             w_ptr;
  logic [WIDTH-1:0] w_word;
  logic [WIDTH-1:0] w_tx;
  logic             w_id;
  logic [WIDTH-1:0] w_cap;
  logic             w_gnt0;
  logic             w_gnt1;
  logic             w_sin;
  logic [WIDTH-1:0] w_rdata;
  logic             w_rid;
  logic             w_rvalid;
  logic             w_rerr;
  logic             w_busy;

  logic             w_any;
  logic             w_win;
  logic [WIDTH-1:0] w_win_data;
  logic [WIDTH-1:0] w_cap_shift;

  // Round-robin pick: on a tie the requester not served last wins.
  always_comb begin
    w_any = req0 | req1;
    if (req0 && req1) begin
      w_win = ~r_ptr;
    end else if (req1) begin
      w_win = 1'b1;
    end else begin
      w_win = 1'b0;
    end
    w_win_data  = w_win ? data1 : data0;
    w_cap_shift = {r_cap[WIDTH-2:0], sOut};
  end

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    w_state  = r_state;
    w_cnt    = r_cnt;
    w_ptr    = r_ptr;
    w_word   = r_word;
    w_tx     = r_tx;
    w_id     = r_id;
    w_cap    = r_cap;
    w_gnt0   = 1'b0;
    w_gnt1   = 1'b0;
    w_sin    = 1'b0;
    w_rdata  = r_rdata;
    w_rid    = r_rid;
    w_rvalid = 1'b0;
    w_rerr   = 1'b0;
    w_busy   = r_busy;

    case (r_state)
      ST_IDLE: begin
        if (w_any) begin
          w_state = ST_RUN;
          w_cnt   = '0;
          w_ptr   = w_win;
          w_word  = w_win_data;
          w_tx    = {w_win_data[WIDTH-2:0], 1'b0};
          w_id    = w_win;
          w_gnt0  = ~w_win;
          w_gnt1  = w_win;
          w_sin   = w_win_data[WIDTH-1];
          w_busy  = 1'b1;
        end else begin
          w_busy  = 1'b0;
        end
      end

      ST_RUN: begin
        w_busy = 1'b1;
        w_cnt  = r_cnt + CNT_ONE;
        // Zeros fill in behind the word, so sIn idles low after the last bit.
        w_tx   = {r_tx[WIDTH-2:0], 1'b0};
        w_sin  = r_tx[WIDTH-1];
        // sOut carries the first data bit DEPTH cycles after it was driven.
        if (r_cnt >= CNT_CAP) begin
          w_cap = w_cap_shift;
        end else begin
          w_cap = r_cap;
        end
        if (r_cnt == CNT_LAST) begin
          w_state  = ST_DONE;
          w_cnt    = '0;
          w_sin    = 1'b0;
          w_rvalid = 1'b1;
          w_rdata  = w_cap_shift;
          w_rid    = r_id;
          w_rerr   = (w_cap_shift != r_word);
        end else begin
          w_state  = ST_RUN;
        end
      end

      ST_DONE: begin
        w_state = ST_IDLE;
        w_busy  = 1'b0;
      end

      default: begin
        w_state = ST_IDLE;
        w_cnt   = '0;
        w_busy  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset abandons any transfer in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_ptr    <= 1'b1;
      r_word   <= '0;
      r_tx     <= '0;
      r_id     <= 1'b0;
      r_cap    <= '0;
      r_gnt0   <= 1'b0;
      r_gnt1   <= 1'b0;
      r_sin    <= 1'b0;
      r_rdata  <= '0;
      r_rid    <= 1'b0;
      r_rvalid <= 1'b0;
      r_rerr   <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_state  <= w_state;
      r_cnt    <= w_cnt;
      r_ptr    <= w_ptr;
      r_word   <= w_word;
      r_tx     <= w_tx;
      r_id     <= w_id;
      r_cap    <= w_cap;
      r_gnt0   <= w_gnt0;
      r_gnt1   <= w_gnt1;
      r_sin    <= w_sin;
      r_rdata  <= w_rdata;
      r_rid    <= w_rid;
      r_rvalid <= w_rvalid;
      r_rerr   <= w_rerr;
      r_busy   <= w_busy;
    end
  end

  assign gnt0   = r_gnt0;
  assign gnt1   = r_gnt1;
  assign sIn    = r_sin;
  assign rdata  = r_rdata;
  assign rid    = r_rid;
  assign rvalid = r_rvalid;
  assign rerr   = r_rerr;
  assign busy   = r_busy;

endmodule

// File: tb/tb_serial_shift_arbiter.sv
// Directed bench for serial_shift_arbiter with a behavioural DEPTH-stage
// shift register closing the serial loop.
module tb_serial_shift_arbiter;

  localparam int W = 8;
  localparam int D = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         req0 = 1'b0;
  logic         req1 = 1'b0;
  logic [W-1:0] data0 = '0;
  logic [W-1:0] data1 = '0;
  logic         gnt0, gnt1, sIn, sOut, rid, rvalid, rerr, busy;
  logic [W-1:0] rdata;

  logic [D-1:0] sr = '0;
  logic         force0 = 1'b0;

  int n_vec = 0;
  int n_miscmp = 0;

  serial_shift_arbiter #(.WIDTH(W), .DEPTH(D)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .data0(data0), .data1(data1),
    .gnt0(gnt0), .gnt1(gnt1), .sIn(sIn), .sOut(sOut),
    .rdata(rdata), .rid(rid), .rvalid(rvalid), .rerr(rerr), .busy(busy)
  );

  always #5 clk = ~clk;

  // External shift register; force0 models a stuck-at-0 return path.
  always @(posedge clk) sr <= {sr[D-2:0], sIn};
  assign sOut = force0 ? 1'b0 : sr[D-1];

  task automatic chk_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miscmp++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Called at the negedge before the granting edge E0; checks S0..S(W+D).
  task automatic xfer(input bit id, input logic [W-1:0] word,
                      input logic [W-1:0] exp_rd, input bit exp_err,
                      input bit drop, input int raise1_at);
    for (int k = 0; k <= W + D; k++) begin
      @(negedge clk);
      chk_vec("gnt", {30'd0, gnt1, gnt0},
              (k == 0) ? (id ? 32'd2 : 32'd1) : 32'd0);
      chk_vec("busy", {31'd0, busy}, 32'd1);
      if (k < W)
        chk_vec("sin_bit", {31'd0, sIn}, {31'd0, word[W-1-k]});
      else if (k < W + D)
        chk_vec("sin_tail", {31'd0, sIn}, 32'd0);
      if (k < W + D) begin
        chk_vec("rvalid_low", {31'd0, rvalid}, 32'd0);
      end else begin
        chk_vec("rvalid", {31'd0, rvalid}, 32'd1);
        chk_vec("rdata", {24'd0, rdata}, {24'd0, exp_rd});
        chk_vec("rid", {31'd0, rid}, {31'd0, id});
        chk_vec("rerr", {31'd0, rerr}, {31'd0, exp_err});
      end
      if (k == 0 && drop) begin
        if (id) req1 = 1'b0;
        else    req0 = 1'b0;
      end
      if (k == raise1_at) begin
        req1  = 1'b1;
        data1 = 8'h96;
      end
    end
  endtask

  task automatic idle_check(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk_vec("idle_gnt", {30'd0, gnt1, gnt0}, 32'd0);
      chk_vec("idle_busy", {31'd0, busy}, 32'd0);
      chk_vec("idle_sin", {31'd0, sIn}, 32'd0);
      chk_vec("idle_rvalid", {31'd0, rvalid}, 32'd0);
    end
  endtask

  // Safety net so the run always terminates.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // Reset asserted mid-clock: outputs go low without waiting for an edge.
    #3 rst = 1'b0;
    #1;
    chk_vec("reset_outs", {17'd0, gnt0, gnt1, sIn, rvalid, rerr, busy, rid, rdata}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    idle_check(20);

    // Tie: grants alternate 0,1,0,1 starting with requester 0.
    data0 = 8'h3C;
    data1 = 8'hC3;
    req0  = 1'b1;
    req1  = 1'b1;
    for (int n = 0; n < 4; n++) begin
      xfer(n[0], n[0] ? 8'hC3 : 8'h3C, n[0] ? 8'hC3 : 8'h3C, 1'b0, 1'b0, -1);
      if (n < 3) begin
        @(negedge clk);
        chk_vec("tie_gap_busy", {31'd0, busy}, 32'd0);
      end
    end
    req0 = 1'b0;
    req1 = 1'b0;
    idle_check(3);

    // Single transfer of A5.
    data0 = 8'hA5;
    req0  = 1'b1;
    xfer(1'b0, 8'hA5, 8'hA5, 1'b0, 1'b1, -1);

    // req1 raised during req0's RUN is served only after the next IDLE.
    data0 = 8'h5A;
    req0  = 1'b1;
    @(negedge clk);
    xfer(1'b0, 8'h5A, 8'h5A, 1'b0, 1'b1, 3);
    @(negedge clk);
    chk_vec("ign_idle_gnt", {30'd0, gnt1, gnt0}, 32'd0);
    xfer(1'b1, 8'h96, 8'h96, 1'b0, 1'b1, -1);
    idle_check(4);

    // Reset at S5 of a transfer: abandoned, pointer back to 1.
    data0 = 8'h77;
    req0  = 1'b1;
    @(negedge clk);
    chk_vec("rst_s0_gnt0", {31'd0, gnt0}, 32'd1);
    req0 = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    #1;
    chk_vec("midrst_outs", {17'd0, gnt0, gnt1, sIn, rvalid, rerr, busy, rid, rdata}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    idle_check(12);
    data0 = 8'h66;
    data1 = 8'h0F;
    req0  = 1'b1;
    req1  = 1'b1;
    xfer(1'b0, 8'h66, 8'h66, 1'b0, 1'b1, -1);
    @(negedge clk);
    xfer(1'b1, 8'h0F, 8'h0F, 1'b0, 1'b1, -1);
    idle_check(2);

    // Stuck-at-0 return path: word FF comes back as 00 with rerr.
    force0 = 1'b1;
    data0  = 8'hFF;
    req0   = 1'b1;
    xfer(1'b0, 8'hFF, 8'h00, 1'b1, 1'b1, -1);
    @(negedge clk);
    chk_vec("post_rvalid", {31'd0, rvalid}, 32'd0);
    chk_vec("post_rerr", {31'd0, rerr}, 32'd0);
    chk_vec("post_rdata_hold", {24'd0, rdata}, 32'h00);
    chk_vec("post_rid_hold", {31'd0, rid}, 32'd0);
    force0 = 1'b0;
    idle_check(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
    $finish;
  end

endmodule
